// File: rtl/adc_reader_pkg.sv
// Shared constants and state encoding for the two-channel ADC reader.
package adc_reader_pkg;

  localparam int ADC_FRAME_BITS = 34;
  localparam int CH0_MSB_POS    = 3;
  localparam int CH1_MSB_POS    = 19;
  localparam int AMP_WORD_BITS  = 8;

  // Capture window keeps frame bits CH0_MSB_POS..ADC_FRAME_BITS only
  localparam int CAP_BITS = ADC_FRAME_BITS - CH0_MSB_POS + 1;
  localparam int CH0_IDX  = ADC_FRAME_BITS - CH0_MSB_POS;
  localparam int CH1_IDX  = ADC_FRAME_BITS - CH1_MSB_POS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_AMP_LOAD = 3'd1,
    ST_AMP_END  = 3'd2,
    ST_CONV     = 3'd3,
    ST_SHIFT    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/adc_reader_sck.sv
// SPI clock generator: toggles sck every HALF cycles while enabled,
// with single-cycle rise/fall pulses on the toggling cycle.
module sck_tick_gen #(
  parameter int HALF = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == LAST);
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_reader.sv
// SPI reader for the two-channel ADC and its preamp: programs gain,
// starts periodic conversions and captures both signed samples.
module adc_reader
  import adc_reader_pkg::*;
#(
  parameter int SCK_HALF      = 3,
  parameter int SAMPLE_PERIOD = 2500,
  parameter int ADC_BITS      = 14
) (
  input  logic                CLK_50M,
  input  logic                reset,
  input  logic                startEnable,
  input  logic [3:0]          gainA,
  input  logic [3:0]          gainB,
  input  logic                gainLoad,
  input  logic                SPI_MISO,
  output logic                SPI_SCK,
  output logic                SPI_MOSI,
  output logic                AMP_CS,
  output logic                AD_CONV,
  output logic [ADC_BITS-1:0] Va,
  output logic [ADC_BITS-1:0] Vb,
  output logic                dataValid,
  output logic                busy
);

  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [7:0] END_LAST   = 8'(SCK_HALF - 1);
  localparam logic [7:0] CONV_LAST  = 8'(2 * SCK_HALF - 1);
  localparam logic [5:0] AMP_LAST   = 6'(AMP_WORD_BITS - 1);
  localparam logic [5:0] SHIFT_LAST = 6'(ADC_FRAME_BITS - 1);

  state_t state, nxt;

  logic                sck_en, rise, fall;
  logic [TW-1:0]       tmr;
  logic                due;
  logic                gain_pend;
  logic [7:0]          gain_lat;
  logic [7:0]          amp_word;
  logic [5:0]          bcnt;
  logic [7:0]          tcnt;
  logic [CAP_BITS-1:0] cap;
  logic                enter;

  assign sck_en = (state == ST_AMP_LOAD) || (state == ST_SHIFT);
  assign enter  = (nxt != state);

  sck_tick_gen #(.HALF(SCK_HALF)) u_sck (
    .clk   (CLK_50M),
    .reset (reset),
    .en    (sck_en),
    .sck   (SPI_SCK),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge CLK_50M) begin
    if (reset) state <= ST_AMP_LOAD;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (gain_pend)               nxt = ST_AMP_LOAD;
        else if (due && startEnable) nxt = ST_CONV;
      end
      ST_AMP_LOAD:
        if (fall && bcnt == AMP_LAST) nxt = ST_AMP_END;
      ST_AMP_END:
        if (tcnt == END_LAST) nxt = ST_IDLE;
      ST_CONV:
        if (tcnt == CONV_LAST) nxt = ST_SHIFT;
      ST_SHIFT:
        if (fall && bcnt == SHIFT_LAST) nxt = ST_DONE;
      ST_DONE:
        nxt = ST_IDLE;
      default:
        nxt = ST_IDLE;
    endcase
  end

  // Outputs forced to their idle levels while reset is held
  always_comb begin
    SPI_MOSI  = 1'b0;
    AMP_CS    = 1'b1;
    AD_CONV   = 1'b0;
    dataValid = 1'b0;
    busy      = 1'b1;
    if (!reset) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_AMP_LOAD: begin
          AMP_CS   = 1'b0;
          SPI_MOSI = amp_word[7];
        end
        ST_CONV: AD_CONV   = 1'b1;
        ST_DONE: dataValid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      tmr <= '0;
      due <= 1'b0;
    end else begin
      tmr <= (tmr == TMR_LAST) ? '0 : tmr + 1'b1;
      if (tmr == TMR_LAST)
        due <= 1'b1;
      else if (state == ST_IDLE && nxt == ST_CONV)
        due <= 1'b0;
    end
  end

  // A request arriving as the load starts stays pending for another pass
  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      gain_pend <= 1'b0;
      gain_lat  <= {gainB, gainA};
      amp_word  <= {gainB, gainA};
    end else begin
      if (gainLoad) begin
        gain_pend <= 1'b1;
        gain_lat  <= {gainB, gainA};
      end else if (state == ST_IDLE && nxt == ST_AMP_LOAD) begin
        gain_pend <= 1'b0;
      end
      if (state == ST_IDLE && nxt == ST_AMP_LOAD)
        amp_word <= gain_lat;
      else if (state == ST_AMP_LOAD && fall)
        amp_word <= {amp_word[6:0], 1'b0};
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset || enter) begin
      bcnt <= '0;
      tcnt <= '0;
    end else begin
      bcnt <= bcnt + {5'd0, fall};
      tcnt <= tcnt + 8'd1;
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      cap <= '0;
      Va  <= '0;
      Vb  <= '0;
    end else begin
      if (state == ST_SHIFT && rise)
        cap <= {cap[CAP_BITS-2:0], SPI_MISO};
      if (state == ST_SHIFT && nxt == ST_DONE) begin
        Va <= cap[CH0_IDX -: ADC_BITS];
        Vb <= cap[CH1_IDX -: ADC_BITS];
      end
    end
  end

endmodule

// File: tb/tb_adc_reader.sv
// Self-checking bench for adc_reader: ADC/preamp bus models,
// sample scoreboard and directed corner sequences.
module tb_adc_reader;

  localparam int SH = 3;
  localparam int SP = 300;

  logic        CLK_50M = 1'b0;
  logic        reset = 1'b1;
  logic        startEnable = 1'b0;
  logic        gainLoad = 1'b0;
  logic        SPI_MISO = 1'b0;
  logic [3:0]  gainA = 4'h1;
  logic [3:0]  gainB = 4'h1;
  logic        SPI_SCK, SPI_MOSI, AMP_CS, AD_CONV, dataValid, busy;
  logic [13:0] Va, Vb;

  adc_reader #(
    .SCK_HALF(SH), .SAMPLE_PERIOD(SP), .ADC_BITS(14)
  ) dut (
    .CLK_50M(CLK_50M), .reset(reset), .startEnable(startEnable),
    .gainA(gainA), .gainB(gainB), .gainLoad(gainLoad),
    .SPI_MISO(SPI_MISO), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
    .AMP_CS(AMP_CS), .AD_CONV(AD_CONV), .Va(Va), .Vb(Vb),
    .dataValid(dataValid), .busy(busy)
  );

  always #5 CLK_50M = ~CLK_50M;

  typedef struct packed {
    logic [13:0] ch0;
    logic [13:0] ch1;
    logic        fill;
    logic [13:0] exp_va;
    logic [13:0] exp_vb;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int failures = 0;

  logic [13:0] cur_ch0 = '0, cur_ch1 = '0;
  logic [13:0] cur_va = '0, cur_vb = '0;
  logic        cur_fill = 1'b0;
  logic [27:0] exp_q [$];
  logic [7:0]  amp_q [$];
  logic [27:0] e;
  logic [33:0] frame = '0;
  logic [7:0]  amp_cap = '0;
  logic        sck_q = 1'b0, cs_q = 1'b1, conv_q = 1'b0;

  int dv_cnt = 0, conv_cnt = 0, amp_cnt = 0;
  int ridx = 0, cyc = 0, last_dv = 0, prev_dv = 0;
  int conv_w = 0, amp_low = 0, amp_rises = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mk_frame(
    input logic [13:0] c0, input logic [13:0] c1, input logic f);
    return {f, f, c0, f, f, c1, f, f};
  endfunction

  function automatic int cnt_of(input int which);
    case (which)
      0: return dv_cnt;
      1: return conv_cnt;
      default: return amp_cnt;
    endcase
  endfunction

  task automatic wait_evt(input int which, input int budget,
                          input string name);
    int start;
    int n;
    start = cnt_of(which);
    n = 0;
    while (cnt_of(which) == start && n < budget) begin
      @(negedge CLK_50M);
      n++;
    end
    if (cnt_of(which) == start) begin
      checks++;
      failures++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  task automatic set_frame(input logic [13:0] c0, input logic [13:0] c1,
                           input logic f, input logic [13:0] ev,
                           input logic [13:0] eb);
    cur_ch0 = c0;
    cur_ch1 = c1;
    cur_fill = f;
    cur_va = ev;
    cur_vb = eb;
  endtask

  // ADC and preamp models plus scoreboard, all sampled on the falling edge
  always @(negedge CLK_50M) begin
    cyc++;
    if (AD_CONV && !conv_q) begin
      conv_cnt++;
      conv_w = 0;
      ridx = 0;
      frame = mk_frame(cur_ch0, cur_ch1, cur_fill);
      exp_q.push_back({cur_va, cur_vb});
      SPI_MISO = frame[33];
    end
    if (AD_CONV) conv_w++;
    if (!AD_CONV && conv_q) chk("adconv_width", conv_w, 2 * SH);
    if (!AMP_CS && cs_q) begin
      amp_cap = '0;
      amp_rises = 0;
      amp_low = 0;
    end
    if (!AMP_CS) amp_low++;
    if (SPI_SCK && !sck_q) begin
      if (!AMP_CS) begin
        amp_cap = {amp_cap[6:0], SPI_MOSI};
        amp_rises++;
      end
      ridx++;
      if (ridx < 34) SPI_MISO = frame[33 - ridx];
    end
    if (AMP_CS && !cs_q) begin
      amp_cnt++;
      if (amp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL amp_unexpected: got word %0h want none", amp_cap);
      end else begin
        chk("amp_word", amp_cap, amp_q.pop_front());
        chk("amp_rises", amp_rises, 8);
        chk("amp_cs_low", amp_low, 16 * SH);
      end
    end
    if (dataValid) begin
      dv_cnt++;
      prev_dv = last_dv;
      last_dv = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dv_unexpected: got Va=%0h Vb=%0h want none", Va, Vb);
      end else begin
        e = exp_q.pop_front();
        chk("va", Va, e[27:14]);
        chk("vb", Vb, e[13:0]);
      end
    end
    sck_q = SPI_SCK;
    cs_q = AMP_CS;
    conv_q = AD_CONV;
  end

  initial begin
    int c_amp, c_conv, c_dv, n;
    vecs[0] = '{14'h1ABC, 14'h2345, 1'b0, 14'h1ABC, 14'h2345};
    vecs[1] = '{14'h2000, 14'h3FFF, 1'b1, 14'h2000, 14'h3FFF};
    vecs[2] = '{14'h0000, 14'h0000, 1'b1, 14'h0000, 14'h0000};
    vecs[3] = '{14'h3FFF, 14'h2000, 1'b0, 14'h3FFF, 14'h2000};
    vecs[4] = '{14'h1555, 14'h2AAA, 1'b1, 14'h1555, 14'h2AAA};

    amp_q.push_back(8'h11);
    repeat (4) @(negedge CLK_50M);
    chk("rst_sck", SPI_SCK, 0);
    chk("rst_mosi", SPI_MOSI, 0);
    chk("rst_cs", AMP_CS, 1);
    chk("rst_conv", AD_CONV, 0);
    chk("rst_va", Va, 0);
    chk("rst_vb", Vb, 0);
    chk("rst_dv", dataValid, 0);
    chk("rst_busy", busy, 1);
    reset = 1'b0;

    wait_evt(2, 200, "amp_after_reset");
    repeat (5) @(negedge CLK_50M);
    chk("idle_busy", busy, 0);
    chk("idle_cs", AMP_CS, 1);

    for (int i = 0; i < 5; i++) begin
      set_frame(vecs[i].ch0, vecs[i].ch1, vecs[i].fill,
                vecs[i].exp_va, vecs[i].exp_vb);
      startEnable = 1'b1;
      wait_evt(0, 2 * SP, "dv_vec");
      @(negedge CLK_50M);
      if (i >= 2) chk("dv_period", last_dv - prev_dv, SP);
    end

    // gain request arriving in the middle of a frame
    set_frame(14'h0F0F, 14'h30F0, 1'b1, 14'h0F0F, 14'h30F0);
    wait_evt(1, SP + 10, "conv_gain");
    repeat (60) @(negedge CLK_50M);
    gainA = 4'h3;
    gainB = 4'h5;
    gainLoad = 1'b1;
    amp_q.push_back(8'h53);
    @(negedge CLK_50M);
    gainLoad = 1'b0;
    wait_evt(0, 300, "dv_gain");
    set_frame(14'h2AAA, 14'h1555, 1'b0, 14'h2AAA, 14'h1555);
    c_amp = amp_cnt;
    c_conv = conv_cnt;
    n = 0;
    while (amp_cnt == c_amp && conv_cnt == c_conv && n < 400) begin
      @(negedge CLK_50M);
      n++;
    end
    chk("amp_before_conv", amp_cnt - c_amp, 1);
    chk("conv_after_amp", conv_cnt - c_conv, 0);

    // startEnable dropped mid-frame: frame still completes
    wait_evt(1, SP + 200, "conv_stop");
    repeat (40) @(negedge CLK_50M);
    startEnable = 1'b0;
    wait_evt(0, 300, "dv_stop");
    @(negedge CLK_50M);
    c_conv = conv_cnt;
    c_dv = dv_cnt;
    repeat (3 * SP) @(negedge CLK_50M);
    chk("stop_no_conv", conv_cnt - c_conv, 0);
    chk("stop_no_dv", dv_cnt - c_dv, 0);
    chk("stop_va_hold", Va, 14'h2AAA);
    chk("stop_vb_hold", Vb, 14'h1555);

    // reset at the 20th SCK rise of a frame
    set_frame(14'h1234, 14'h0DEF, 1'b0, 14'h1234, 14'h0DEF);
    startEnable = 1'b1;
    wait_evt(1, SP + 10, "conv_reset");
    n = 0;
    while (ridx < 20 && n < 300) begin
      @(negedge CLK_50M);
      n++;
    end
    chk("rise20_reached", ridx, 20);
    reset = 1'b1;
    startEnable = 1'b0;
    exp_q.delete();
    amp_q.push_back(8'h53);
    @(negedge CLK_50M);
    chk("mid_rst_sck", SPI_SCK, 0);
    chk("mid_rst_conv", AD_CONV, 0);
    chk("mid_rst_va", Va, 0);
    chk("mid_rst_vb", Vb, 0);
    chk("mid_rst_dv", dataValid, 0);
    chk("mid_rst_busy", busy, 1);
    repeat (3) @(negedge CLK_50M);
    c_dv = dv_cnt;
    reset = 1'b0;
    wait_evt(2, 200, "amp_after_midrst");
    repeat (SP) @(negedge CLK_50M);
    chk("midrst_no_dv", dv_cnt - c_dv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
